player_motion: RTL and testbench



---
 rtl/maze_pkg.sv | 61 ++++++
 rtl/maze_hit.sv | 36 +++
 rtl/player_motion.sv | 193 +++++++++++++++++++
 tb/tb_player_motion.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze geometry, start table and game state encoding for the player
// motion block and the pixel colouring controller.
package maze_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GAME_INIT = 3'd1,
        MOVE      = 3'd2,
        STILL     = 3'd3,
        CHECK     = 3'd4,
        FINISH    = 3'd5
    } game_state_t;

    localparam int SCREEN_W            = 640;
    localparam int SCREEN_H            = 480;
    localparam int DEFAULT_PLAYER_SIZE = 25;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } point_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] w;
        logic [9:0] h;
    } rect_t;

    localparam point_t L1_START = '{x: 10'd113, y: 10'd443};
    localparam point_t L2_START = '{x: 10'd33,  y: 10'd443};
    localparam point_t L3_START = '{x: 10'd13,  y: 10'd230};

    // Each level is a pair of corridors; the finish box sits inside one of them.
    localparam rect_t L1_WALK0  = '{x: 10'd100, y: 10'd0,   w: 10'd50,  h: 10'd480};
    localparam rect_t L1_WALK1  = '{x: 10'd100, y: 10'd0,   w: 10'd540, h: 10'd50};
    localparam rect_t L1_FINISH = '{x: 10'd500, y: 10'd0,   w: 10'd140, h: 10'd50};
    localparam rect_t L2_WALK0  = '{x: 10'd20,  y: 10'd420, w: 10'd620, h: 10'd60};
    localparam rect_t L2_WALK1  = '{x: 10'd20,  y: 10'd200, w: 10'd50,  h: 10'd280};
    localparam rect_t L2_FINISH = '{x: 10'd590, y: 10'd430, w: 10'd50,  h: 10'd50};
    localparam rect_t L3_WALK0  = '{x: 10'd0,   y: 10'd220, w: 10'd620, h: 10'd35};
    localparam rect_t L3_WALK1  = '{x: 10'd0,   y: 10'd100, w: 10'd40,  h: 10'd155};
    localparam rect_t L3_FINISH = '{x: 10'd570, y: 10'd220, w: 10'd50,  h: 10'd35};

    function automatic point_t start_pos(input logic [1:0] level);
        point_t p;
        case (level)
            2'd1:    p = L1_START;
            2'd2:    p = L2_START;
            2'd3:    p = L3_START;
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic in_rect(input logic [9:0] col, input logic [9:0] row, input rect_t r);
        return (col >= r.x) && ({1'b0, col} < ({1'b0, r.x} + {1'b0, r.w})) &&
               (row >= r.y) && ({1'b0, row} < ({1'b0, r.y} + {1'b0, r.h}));
    endfunction

endpackage

// File: rtl/maze_hit.sv
// Combinational point classifier: is (col,row) inside the level's walkable
// corridors, and is it inside the level's finish box.
module maze_hit
    import maze_pkg::*;
(
    input  logic [9:0] col,
    input  logic [9:0] row,
    input  logic [1:0] level,
    output logic       walkable,
    output logic       in_finish
);

    always_comb begin
        walkable  = 1'b0;
        in_finish = 1'b0;
        case (level)
            2'd1: begin
                walkable  = in_rect(col, row, L1_WALK0) | in_rect(col, row, L1_WALK1);
                in_finish = in_rect(col, row, L1_FINISH);
            end
            2'd2: begin
                walkable  = in_rect(col, row, L2_WALK0) | in_rect(col, row, L2_WALK1);
                in_finish = in_rect(col, row, L2_FINISH);
            end
            2'd3: begin
                walkable  = in_rect(col, row, L3_WALK0) | in_rect(col, row, L3_WALK1);
                in_finish = in_rect(col, row, L3_FINISH);
            end
            default: begin
                walkable  = 1'b0;
                in_finish = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/player_motion.sv
// Per-frame player position update from tilt, with a four-cycle corner
// check against the level maze, wall-hit restart and finish detection.
module player_motion
    import maze_pkg::*;
#(
    parameter int TILT_SHIFT  = 4,
    parameter int DEADZONE    = 16,
    parameter int MAX_STEP    = 8,
    parameter int PLAYER_SIZE = DEFAULT_PLAYER_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    // frame_tick: single-cycle pulse; taken only in GAME_INIT/MOVE/STILL, dropped otherwise.
    input  logic             frame_tick,
    input  logic [1:0]       level_select,
    input  logic             level_lock,
    input  logic             KEY0,
    input  logic signed [8:0] tilt_x,
    input  logic signed [8:0] tilt_y,
    output logic [9:0]       player_x,
    output logic [9:0]       player_y,
    output logic [2:0]       game_state,
    output logic             collided,
    output logic             finished
);

    localparam logic signed [10:0] DZ    = 11'(DEADZONE);
    localparam logic signed [10:0] MAX_S = 11'(MAX_STEP);
    localparam logic [9:0]         X_MAX = 10'(SCREEN_W - PLAYER_SIZE);
    localparam logic [9:0]         Y_MAX = 10'(SCREEN_H - PLAYER_SIZE);
    localparam logic [9:0]         EDGE  = 10'(PLAYER_SIZE - 1);

    function automatic logic signed [10:0] axis_step(input logic signed [8:0] tilt);
        logic signed [10:0] wide;
        logic signed [10:0] s;
        wide = {{2{tilt[8]}}, tilt};
        s    = wide >>> TILT_SHIFT;
        if ((wide < DZ) && (wide > -DZ)) s = '0;
        else if (s > MAX_S)              s = MAX_S;
        else if (s < -MAX_S)             s = -MAX_S;
        return s;
    endfunction

    function automatic logic [9:0] axis_clamp(input logic [9:0] pos, input logic signed [10:0] s,
                                              input logic [9:0] hi);
        logic signed [10:0] sum;
        sum = $signed({1'b0, pos}) + s;
        if (sum < 11'sd0)                  return '0;
        if (sum > $signed({1'b0, hi}))     return hi;
        return sum[9:0];
    endfunction

    game_state_t        state_q, state_d;
    logic [9:0]         px_q, px_d, py_q, py_d;
    logic [9:0]         cx_q, cx_d, cy_q, cy_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               bad_q, bad_d, fin_q, fin_d;
    logic [1:0]         level_q, level_d;
    logic               collided_q, collided_d, finished_q, finished_d;

    logic signed [10:0] step_x, step_y;
    logic               step_nz;
    logic [9:0]         hit_col, hit_row;
    logic               walkable, in_finish;
    logic               hit_bad, hit_fin;
    point_t             start_cur, start_sel;

    assign step_x  = axis_step(tilt_x);
    assign step_y  = axis_step(tilt_y);
    assign step_nz = (step_x != '0) || (step_y != '0);

    // Corner order TL, TR, BL, BR follows the check counter.
    always_comb begin
        hit_col = cnt_q[0] ? cx_q + EDGE : cx_q;
        hit_row = cnt_q[1] ? cy_q + EDGE : cy_q;
    end

    maze_hit u_maze_hit (
        .col       (hit_col),
        .row       (hit_row),
        .level     (level_q),
        .walkable  (walkable),
        .in_finish (in_finish)
    );

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        py_d       = py_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        cnt_d      = cnt_q;
        bad_d      = bad_q;
        fin_d      = fin_q;
        level_d    = level_q;
        collided_d = 1'b0;
        hit_bad    = bad_q | ~walkable;
        hit_fin    = fin_q | in_finish;
        start_cur  = start_pos(level_q);
        start_sel  = start_pos(level_select);

        if (!level_lock) begin
            state_d = IDLE;
            level_d = level_select;
            px_d    = start_sel.x;
            py_d    = start_sel.y;
        end else begin
            unique case (state_q)
                IDLE: begin
                    level_d = level_select;
                    px_d    = start_sel.x;
                    py_d    = start_sel.y;
                    state_d = GAME_INIT;
                end
                GAME_INIT, MOVE, STILL: begin
                    if (frame_tick) begin
                        if (step_nz) begin
                            cx_d    = axis_clamp(px_q, step_x, X_MAX);
                            cy_d    = axis_clamp(py_q, step_y, Y_MAX);
                            cnt_d   = 2'd0;
                            bad_d   = 1'b0;
                            fin_d   = 1'b0;
                            state_d = CHECK;
                        end else if (state_q != GAME_INIT) begin
                            state_d = STILL;
                        end
                    end
                end
                CHECK: begin
                    cnt_d = cnt_q + 2'd1;
                    bad_d = hit_bad;
                    fin_d = hit_fin;
                    if (cnt_q == 2'd3) begin
                        if (hit_bad) begin
                            px_d       = start_cur.x;
                            py_d       = start_cur.y;
                            collided_d = 1'b1;
                            state_d    = GAME_INIT;
                        end else begin
                            px_d    = cx_q;
                            py_d    = cy_q;
                            state_d = hit_fin ? FINISH : MOVE;
                        end
                    end
                end
                FINISH: begin
                    if (!KEY0) begin
                        px_d    = start_cur.x;
                        py_d    = start_cur.y;
                        state_d = GAME_INIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        finished_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            px_q       <= L1_START.x;
            py_q       <= L1_START.y;
            cx_q       <= '0;
            cy_q       <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            fin_q      <= 1'b0;
            level_q    <= 2'd1;
            collided_q <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            py_q       <= py_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            cnt_q      <= cnt_d;
            bad_q      <= bad_d;
            fin_q      <= fin_d;
            level_q    <= level_d;
            collided_q <= collided_d;
            finished_q <= finished_d;
        end
    end

    assign player_x   = px_q;
    assign player_y   = py_q;
    assign game_state = state_q;
    assign collided   = collided_q;
    assign finished   = finished_q;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed scenarios plus random tilt walks, checked
// against a frame-level reference model through an expected-result queue.
module tb_player_motion;
    import maze_pkg::*;

    localparam int PSZ   = 25;
    localparam int X_TOP = 640 - PSZ;
    localparam int Y_TOP = 480 - PSZ;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_tick = 1'b0;
    logic [1:0]        level_select = 2'd1;
    logic              level_lock = 1'b0;
    logic              KEY0 = 1'b1;
    logic signed [8:0] tilt_x = '0;
    logic signed [8:0] tilt_y = '0;
    logic [9:0]        player_x, player_y;
    logic [2:0]        game_state;
    logic              collided, finished;

    player_motion dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .level_select (level_select),
        .level_lock   (level_lock),
        .KEY0         (KEY0),
        .tilt_x       (tilt_x),
        .tilt_y       (tilt_y),
        .player_x     (player_x),
        .player_y     (player_y),
        .game_state   (game_state),
        .collided     (collided),
        .finished     (finished)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          due;
        string       name;
        int          x;
        int          y;
        game_state_t st;
        bit          col;
        bit          fin;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;
    int   checks = 0;
    int   passes = 0;
    int   seen_cols = 0;
    int   exp_cols = 0;

    always @(negedge clk) begin
        if (collided === 1'b1) seen_cols++;
        while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            got = exp_q.pop_front();
            checks++;
            if (got.due < cyc)
                $display("FAIL %s: expectation due at cycle %0d reached only at %0d", got.name, got.due, cyc);
            else if (player_x === 10'(got.x) && player_y === 10'(got.y) && game_state === got.st &&
                     collided === got.col && finished === got.fin)
                passes++;
            else
                $display("FAIL %s: got x=%0d y=%0d st=%0d col=%b fin=%b, expected x=%0d y=%0d st=%0d col=%b fin=%b",
                         got.name, player_x, player_y, game_state, collided, finished,
                         got.x, got.y, got.st, got.col, got.fin);
        end
    end

    // ---------------- reference model ----------------
    int          m_x = 113, m_y = 443, m_lv = 1;
    game_state_t m_st = IDLE;

    function automatic bit in_box(int c, int r, int x0, int x1, int y0, int y1);
        return c >= x0 && c <= x1 && r >= y0 && r <= y1;
    endfunction

    function automatic bit walk_at(int lv, int c, int r);
        case (lv)
            1: return in_box(c, r, 100, 149, 0, 479) || in_box(c, r, 100, 639, 0, 49);
            2: return in_box(c, r, 20, 639, 420, 479) || in_box(c, r, 20, 69, 200, 479);
            3: return in_box(c, r, 0, 619, 220, 254) || in_box(c, r, 0, 39, 100, 254);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit finish_at(int lv, int c, int r);
        case (lv)
            1: return in_box(c, r, 500, 639, 0, 49);
            2: return in_box(c, r, 590, 639, 430, 479);
            3: return in_box(c, r, 570, 619, 220, 254);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int start_x(int lv);
        case (lv) 1: return 113; 2: return 33; 3: return 13; default: return 0; endcase
    endfunction

    function automatic int start_y(int lv);
        case (lv) 1: return 443; 2: return 443; 3: return 230; default: return 0; endcase
    endfunction

    // Floor division by 16, dead zone, then clamp to +/-8.
    function automatic int step_of(int tilt);
        int s;
        if (tilt > -16 && tilt < 16) return 0;
        s = (tilt >= 0) ? tilt / 16 : -((-tilt + 15) / 16);
        if (s > 8)  s = 8;
        if (s < -8) s = -8;
        return s;
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_frame(input int tx, input int ty, output bit col);
        int sx, sy, cx, cy, cc, cr;
        bit ok, fin;
        col = 1'b0;
        sx  = step_of(tx);
        sy  = step_of(ty);
        if (m_st == GAME_INIT || m_st == MOVE || m_st == STILL) begin
            if (sx == 0 && sy == 0) begin
                if (m_st != GAME_INIT) m_st = STILL;
            end else begin
                cx  = clampi(m_x + sx, 0, X_TOP);
                cy  = clampi(m_y + sy, 0, Y_TOP);
                ok  = 1'b1;
                fin = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    cc = cx + ((k % 2 == 1) ? PSZ - 1 : 0);
                    cr = cy + ((k >= 2) ? PSZ - 1 : 0);
                    if (!walk_at(m_lv, cc, cr)) ok = 1'b0;
                    if (finish_at(m_lv, cc, cr)) fin = 1'b1;
                end
                if (!ok) begin
                    m_x  = start_x(m_lv);
                    m_y  = start_y(m_lv);
                    m_st = GAME_INIT;
                    col  = 1'b1;
                    exp_cols++;
                end else begin
                    m_x  = cx;
                    m_y  = cy;
                    m_st = fin ? FINISH : MOVE;
                end
            end
        end
    endtask

    task automatic expect_at(input int due, input string name, input bit col);
        exp_t ne;
        ne.due  = due;
        ne.name = name;
        ne.x    = m_x;
        ne.y    = m_y;
        ne.st   = m_st;
        ne.col  = col;
        ne.fin  = (m_st == FINISH);
        exp_q.push_back(ne);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_frame(input int tx, input int ty, input string name);
        int c0;
        bit col;
        @(posedge clk); #1;
        tilt_x     = 9'(tx);
        tilt_y     = 9'(ty);
        frame_tick = 1'b1;
        c0         = cyc;
        model_frame(tx, ty, col);
        expect_at(c0 + 5, name, col);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic lock_level(input int lv, input string name);
        @(posedge clk); #1;
        level_select = 2'(lv);
        level_lock   = 1'b1;
        m_lv = lv; m_x = start_x(lv); m_y = start_y(lv); m_st = GAME_INIT;
        expect_at(cyc + 1, name, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    task automatic unlock(input string name);
        @(posedge clk); #1;
        level_lock = 1'b0;
        m_lv = int'(level_select); m_x = start_x(m_lv); m_y = start_y(m_lv); m_st = IDLE;
        expect_at(cyc + 1, name, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    task automatic select_idle(input int lv, input string name);
        @(posedge clk); #1;
        level_select = 2'(lv);
        m_lv = lv; m_x = start_x(lv); m_y = start_y(lv); m_st = IDLE;
        expect_at(cyc + 1, name, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    task automatic press_key(input string name);
        @(posedge clk); #1;
        KEY0 = 1'b0;
        if (m_st == FINISH) begin
            m_st = GAME_INIT; m_x = start_x(m_lv); m_y = start_y(m_lv);
        end
        expect_at(cyc + 1, name, 1'b0);
        @(posedge clk); #1;
        KEY0 = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // A second tick lands while the first move is still being checked.
    task automatic double_tick(input int tx, input string name);
        int c0;
        bit col;
        @(posedge clk); #1;
        tilt_x = 9'(tx); tilt_y = '0; frame_tick = 1'b1; c0 = cyc;
        model_frame(tx, 0, col);
        expect_at(c0 + 5, name, col);
        expect_at(c0 + 10, {name, "_after"}, 1'b0);
        @(posedge clk); #1; frame_tick = 1'b0;
        @(posedge clk); #1; frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        repeat (9) @(posedge clk);
    endtask

    task automatic abort_check(input int tx, input string name);
        int c0;
        @(posedge clk); #1;
        tilt_x = 9'(tx); tilt_y = '0; frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        @(posedge clk); #1;
        level_lock = 1'b0; c0 = cyc;
        m_lv = int'(level_select); m_x = start_x(m_lv); m_y = start_y(m_lv); m_st = IDLE;
        expect_at(c0 + 1, name, 1'b0);
        expect_at(c0 + 5, {name, "_late"}, 1'b0);
        repeat (7) @(posedge clk);
    endtask

    task automatic reset_in_check(input string name);
        @(posedge clk); #1;
        tilt_x = 9'sd64; tilt_y = '0; frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; level_lock = 1'b0;
        m_x = 113; m_y = 443; m_st = IDLE;
        expect_at(cyc, name, 1'b0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        m_lv = int'(level_select); m_x = start_x(m_lv); m_y = start_y(m_lv);
        expect_at(cyc + 1, {name, "_release"}, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    function automatic int rand_tilt();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 511)) - 256;
        return int'($urandom_range(0, 40)) - 20;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        expect_at(1, "reset_values", 1'b0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;

        lock_level(1, "l1_lock");
        for (int i = 0; i < 3; i++) do_frame(0, 0, "l1_zero_tilt");
        do_frame(0, -64, "l1_up");
        do_frame(0, 0, "l1_still");

        unlock("l1_unlock");
        lock_level(1, "l1_relock");
        for (int i = 0; i < 4; i++) do_frame(64, 0, "l1_right_wall");

        unlock("l3_unlock_a");
        select_idle(3, "l3_select");
        lock_level(3, "l3_lock");
        do_frame(15, 0, "deadzone_pos");
        do_frame(-15, 0, "deadzone_neg");
        do_frame(-16, 0, "step_minus1");
        do_frame(255, 0, "clamp_plus8");
        for (int i = 0; i < 4; i++) do_frame(-256, 0, "left_edge_clamp");

        unlock("l3_unlock_b");
        lock_level(3, "l3_relock");
        for (int i = 0; i < 77; i++) do_frame(127, 0, "l3_run");
        do_frame(127, 0, "finish_frozen");
        press_key("finish_restart");

        unlock("l2_unlock");
        select_idle(2, "l2_select");
        lock_level(2, "l2_lock");
        for (int i = 0; i < 3; i++) do_frame(0, 255, "bottom_clamp");
        do_frame(64, 0, "l2_right");
        double_tick(64, "tick_in_check");
        abort_check(64, "lock_drop_in_check");
        select_idle(3, "idle_follows_select");

        lock_level(1, "key_ignore_lock");
        press_key("key_ignored");

        unlock("pre_reset_unlock");
        lock_level(3, "pre_reset_lock");
        reset_in_check("reset_mid_check");

        for (int lv = 1; lv <= 3; lv++) begin
            select_idle(lv, "rand_select");
            lock_level(lv, "rand_lock");
            for (int i = 0; i < 40; i++) begin
                do_frame(rand_tilt(), rand_tilt(), "rand_frame");
                if ($urandom_range(0, 7) == 0) press_key("rand_key");
            end
            unlock("rand_unlock");
        end

        repeat (12) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        checks++;
        if (seen_cols == exp_cols) passes++;
        else $display("FAIL collided_count: saw %0d pulses, expected %0d", seen_cols, exp_cols);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
